// File: rtl/mseq_pkg.sv
// mseq_pkg: shared definitions for the m-sequence receiver (mseq_sync) and
// any generator/bench that needs the same LFSR convention.
package mseq_pkg;

    // Default LFSR width and a primitive tap mask for it
    localparam int         N_DEF  = 5;
    localparam logic [4:0] TAPS_5 = 5'b10100;

    // Widest LFSR the helper function handles
    localparam int LFSR_MAX_W = 32;

    // sync_state encoding seen on the output port
    localparam logic [1:0] ST_ACQ    = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    typedef enum logic [1:0] {
        S_ACQ    = ST_ACQ,
        S_VERIFY = ST_VERIFY,
        S_LOCK   = ST_LOCK
    } sync_st_e;

    // One generator step: chip = parity of tapped bits, state shifts left
    // with the chip entering at the LSB. Result is {next_state, chip}.
    // Narrower LFSRs pass zero-extended operands and keep the low bits.
    function automatic logic [LFSR_MAX_W:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] fase,
        input logic [LFSR_MAX_W-1:0] type_f
    );
        logic chip;
        chip = ^(fase & type_f);
        return {fase[LFSR_MAX_W-2:0], chip, chip};
    endfunction

endpackage

// File: rtl/mseq_sync_if.sv
// mseq_sync_if: chip stream input, tap mask and sync status/statistics.
// Optional MSEQ_SYNC_BER_EN adds the compared-bit counter bit_cnt.
interface mseq_sync_if #(
    parameter int N     = 5,
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             bit_vld;
    logic [N-1:0]     type_f;
    logic             locked;
    logic [1:0]       sync_state;
    logic             bit_err;
    logic [CNT_W-1:0] err_cnt;
    logic [N-1:0]     fase_est;
`ifdef MSEQ_SYNC_BER_EN
    logic [31:0]      bit_cnt;
`endif

    // Chip source / status consumer side
    modport master (
        output bit_in, bit_vld, type_f,
        input  locked, sync_state, bit_err, err_cnt, fase_est
`ifdef MSEQ_SYNC_BER_EN
        , input bit_cnt
`endif
    );

    // Receiver side
    modport slave (
        input  bit_in, bit_vld, type_f,
        output locked, sync_state, bit_err, err_cnt, fase_est
`ifdef MSEQ_SYNC_BER_EN
        , output bit_cnt
`endif
    );

endinterface

// File: rtl/mseq_err_mon.sv
// mseq_err_mon: error bookkeeping while locked. Tracks errors inside
// fixed-length observation blocks, flags loss of lock when a block collects
// ERR_THR errors, and keeps the saturating lifetime error count.
// Optional MSEQ_SYNC_BER_EN adds a saturating count of compared bits.
module mseq_err_mon
    import mseq_pkg::*;
#(
    parameter int WIN_LEN = 31,
    parameter int ERR_THR = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_blk_i,   // entering LOCK: start a fresh block
    input  logic             lock_vld_i,  // a valid chip is compared in LOCK
    input  logic             mism_i,      // that chip mismatched the prediction
    output logic             loss_o,      // this chip is the ERR_THR-th block error
    output logic [CNT_W-1:0] err_cnt_o
`ifdef MSEQ_SYNC_BER_EN
    ,
    output logic [31:0]      bit_cnt_o
`endif
);

    localparam int BLK_W  = $clog2(WIN_LEN + 1);
    localparam int BERR_W = $clog2(ERR_THR + 1);
    localparam logic [BLK_W-1:0]  WIN_LAST = BLK_W'(WIN_LEN - 1);
    localparam logic [BERR_W-1:0] ERR_LAST = BERR_W'(ERR_THR - 1);

    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [BERR_W-1:0] blk_err_q, blk_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef MSEQ_SYNC_BER_EN
    logic [31:0]       bit_cnt_q, bit_cnt_d;
`endif

    // Threshold hit is decided on the incoming error, before any block wrap,
    // so an error on the last chip of a block still costs the lock.
    assign loss_o = lock_vld_i && mism_i && (blk_err_q == ERR_LAST);

    // Next-state of block position, block errors and lifetime counters
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blk_err_d = blk_err_q;
        err_cnt_d = err_cnt_q;
`ifdef MSEQ_SYNC_BER_EN
        bit_cnt_d = bit_cnt_q;
`endif
        if (clr_blk_i) begin
            blk_cnt_d = '0;
            blk_err_d = '0;
        end else if (lock_vld_i) begin
            if (blk_cnt_q == WIN_LAST) begin
                blk_cnt_d = '0;
                blk_err_d = '0;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
                blk_err_d = blk_err_q + BERR_W'(mism_i);
            end
            if (mism_i && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
`ifdef MSEQ_SYNC_BER_EN
            if (bit_cnt_q != '1) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
`endif
        end
    end

    // Counter registers; lifetime counters clear only on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
            blk_err_q <= '0;
            err_cnt_q <= '0;
`ifdef MSEQ_SYNC_BER_EN
            bit_cnt_q <= '0;
`endif
        end else begin
            blk_cnt_q <= blk_cnt_d;
            blk_err_q <= blk_err_d;
            err_cnt_q <= err_cnt_d;
`ifdef MSEQ_SYNC_BER_EN
            bit_cnt_q <= bit_cnt_d;
`endif
        end
    end

    assign err_cnt_o = err_cnt_q;
`ifdef MSEQ_SYNC_BER_EN
    assign bit_cnt_o = bit_cnt_q;
`endif

endmodule

// File: rtl/mseq_sync.sv
// mseq_sync: m-sequence receiver. Loads the generator state from the
// received chips (ACQ), confirms it against VERIFY_LEN predicted chips
// (VERIFY), then flywheels the local LFSR and monitors chip errors (LOCK).
// Optional MSEQ_SYNC_BER_EN exposes a compared-bit counter for BER.
module mseq_sync
    import mseq_pkg::*;
#(
    parameter int N          = 5,
    parameter int VERIFY_LEN = 31,
    parameter int WIN_LEN    = 31,
    parameter int ERR_THR    = 4,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    mseq_sync_if.slave  bus
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int RUN_W  = $clog2(VERIFY_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_N   = FILL_W'(N);
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(VERIFY_LEN - 1);

    sync_st_e          state_q, state_d;
    logic [N-1:0]      fase_q, fase_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              bit_err_q, bit_err_d;
    logic [N-1:0]      type_q;

    logic [N:0]        step_w;
    logic              pred;
    logic [N-1:0]      pred_fase;
    logic [N-1:0]      rcv_fase;
    logic              mism;
    logic              type_chg;
    logic              lock_vld;
    logic              clr_blk;
    logic              loss;

    // Local prediction from the current estimate and the live tap mask
    always_comb begin
        step_w    = (N + 1)'(lfsr_next(LFSR_MAX_W'(fase_q), LFSR_MAX_W'(bus.type_f)));
        pred      = step_w[0];
        pred_fase = step_w[N:1];
        rcv_fase  = {fase_q[N-2:0], bus.bit_in};
    end

    assign mism     = bus.bit_in ^ pred;
    assign type_chg = (bus.type_f != type_q);
    // A tap-mask change pre-empts the chip, so it is not scored in LOCK either
    assign lock_vld = bus.bit_vld && !type_chg && (state_q == S_LOCK);

    // Sync FSM: next state, estimate, fill/run counters and error pulse
    always_comb begin
        state_d   = state_q;
        fase_d    = fase_q;
        fill_d    = fill_q;
        run_d     = run_q;
        bit_err_d = 1'b0;
        clr_blk   = 1'b0;
        if (type_chg) begin
            // New polynomial: the current estimate is meaningless
            state_d = S_ACQ;
            fill_d  = '0;
        end else if (bus.bit_vld) begin
            case (state_q)
                S_ACQ: begin
                    fase_d = rcv_fase;
                    fill_d = (fill_q == FILL_N) ? fill_q : fill_q + 1'b1;
                    // The all-zero lock-up state would verify trivially; skip it
                    if ((fill_d == FILL_N) && (rcv_fase != '0)) begin
                        state_d = S_VERIFY;
                        run_d   = '0;
                    end
                end
                S_VERIFY: begin
                    if (!mism) begin
                        fase_d = pred_fase;
                        run_d  = run_q + 1'b1;
                        if (run_q == RUN_LAST) begin
                            state_d = S_LOCK;
                            clr_blk = 1'b1;
                        end
                    end else begin
                        bit_err_d = 1'b1;
                        fase_d    = rcv_fase;
                        state_d   = S_ACQ;
                        fill_d    = '0;
                    end
                end
                S_LOCK: begin
                    // Flywheel: received chips never steer the estimate here
                    fase_d    = pred_fase;
                    bit_err_d = mism;
                    if (loss) begin
                        state_d = S_ACQ;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = S_ACQ;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // FSM and estimator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ACQ;
            fase_q    <= '0;
            fill_q    <= '0;
            run_q     <= '0;
            bit_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fase_q    <= fase_d;
            fill_q    <= fill_d;
            run_q     <= run_d;
            bit_err_q <= bit_err_d;
        end
    end

    // Tap-mask shadow; tracks through reset so release does not look like a change
    always_ff @(posedge clk) begin
        type_q <= bus.type_f;
    end

    mseq_err_mon #(
        .WIN_LEN (WIN_LEN),
        .ERR_THR (ERR_THR),
        .CNT_W   (CNT_W)
    ) u_err_mon (
        .clk        (clk),
        .rst        (rst),
        .clr_blk_i  (clr_blk),
        .lock_vld_i (lock_vld),
        .mism_i     (mism),
        .loss_o     (loss),
        .err_cnt_o  (bus.err_cnt)
`ifdef MSEQ_SYNC_BER_EN
        ,
        .bit_cnt_o  (bus.bit_cnt)
`endif
    );

    assign bus.sync_state = state_q;
    assign bus.locked     = (state_q == S_LOCK);
    assign bus.bit_err    = bit_err_q;
    assign bus.fase_est   = fase_q;

endmodule
